seq_bit_serializer: RTL and testbench
=====================================

// Module: seq_bit_serializer
// PURPOSE
//  Upstream feeder for the serial sequence detector. Accepts parallel words on a
//  valid/ready handshake and shifts them out one bit per clock on ser_bit, which
//  drives the detector's data input directly. Double-buffered (shifter + hold
//  register) so back-to-back words stream with no idle gap. Drives IDLE_BIT when
//  it has no data, because the detector samples its input every cycle.
// PARAMETERS
//  WIDTH      7   bits per word (matches 7-bit detector pattern)
//  MSB_FIRST  0   0: in_data[0] shifted first (detector compares seq[0] first); 1: in_data[WIDTH-1] first
//  IDLE_BIT   0   value driven on ser_bit when ser_valid=0
// PORTS
//  clk         in   1      clock, all state on posedge
//  rst         in   1      synchronous, active-high reset
//  in_data     in   WIDTH  parallel word
//  in_valid    in   1      in_data valid
//  in_ready    out  1      word accepted when in_valid && in_ready
//  ser_bit     out  1      serial bit to detector (registered)
//  ser_valid   out  1      ser_bit carries word data (registered)
//  word_start  out  1      high with the first bit of each word (registered)
//  busy        out  1      shifter or hold register occupied
// BEHAVIOUR
//  - Reset: ser_bit=IDLE_BIT, ser_valid=0, word_start=0, busy=0, shifter+hold empty,
//    state IDLE. in_ready forced 0 while rst=1. Reset mid-word discards both shifter
//    and held word; no partial word resumes after reset.
//  - in_ready = !hold_full (registered state only, no combinational path from in_valid).
//  - FSM: IDLE -> SHIFT on load; SHIFT stays while bits remain; on last bit: load
//    next word (hold, else accepted word) and stay SHIFT, else -> IDLE.
//  - Load rule: accepted word goes straight to shifter if shifter is IDLE or on its
//    last-bit cycle and hold is empty; otherwise into hold. On last bit with hold
//    full, hold moves to shifter; a word accepted that same cycle goes into hold.
//  - Latency: word accepted at edge N -> first bit on ser_bit after edge N+1
//    (word_start=1), WIDTH consecutive cycles of ser_valid=1.
//  - Bit counter width $clog2(WIDTH+1); counts 0..WIDTH-1, no wrap beyond.
//  - Idle: ser_valid=0, ser_bit=IDLE_BIT. Back-to-back: zero gap between words.
//  - busy = (state!=IDLE) || hold_full.
// CONFIGURATION
//  SER_PARITY_EN defined: after the WIDTH data bits, one extra state PARITY emits
//    even parity (^word) with ser_valid=1; word period becomes WIDTH+1 cycles;
//    next word loads on the parity cycle instead of the last data bit.
//  SER_PARITY_EN undefined: no PARITY state, word period exactly WIDTH cycles.
// STRUCTURE
//  seq_pkg: ser_state_t enum {IDLE, SHIFT, PARITY}, default SEQ_WIDTH=7 constant,
//    shared with the detector.
//  Sub-module ser_word_buffer: single-entry hold register with full flag,
//    push/pop, and in_ready generation; FSM/shifter stay in top.
// TESTING
//  1. rst high 3 cycles, in_valid=1 -> in_ready=0, ser_valid=0, ser_bit=0.
//  2. Send 7'h53 (1010011), MSB_FIRST=0 -> ser_bit 1,1,0,0,1,0,1 with ser_valid=1,
//     word_start on first bit; detector match asserts on the 7th bit.
//  3. in_valid held with 3 words 7'h53,7'h2A,7'h7F -> 21 contiguous valid bits,
//     word_start every 7 cycles, in_ready drops while hold full.
//  4. Reset asserted on bit 3 of a word with hold full -> next cycle ser_valid=0,
//     busy=0; no bits of either word appear afterwards.
//  5. Word accepted on last-bit cycle, hold empty -> next word's first bit follows
//     immediately, no gap, hold stays empty.
//  6. SER_PARITY_EN, send 7'h53 (4 ones) -> 7 data bits then parity bit 0; 8-cycle period.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: serializer state encoding and word width shared with the sequence detector.
package seq_pkg;

    localparam int SEQ_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } ser_state_t;

endpackage

// File: rtl/ser_word_buffer.sv
// ser_word_buffer: single-entry hold register behind the shifter; owns in_ready.
module ser_word_buffer
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             in_ready
);

    // Registered state only, so upstream sees no path from in_valid to in_ready.
    assign in_ready = !full && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else begin
            full <= push || (full && !pop);
            if (push) dout <= din;
        end
    end

endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: double-buffered word-to-bit serializer feeding the sequence detector.
// Define SER_PARITY_EN to append an even-parity bit after every word.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH     = SEQ_WIDTH,
    parameter bit   MSB_FIRST = 1'b0,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] next_word;
    logic [CW-1:0]    cnt;
    logic             par;
    logic             hold_full;
    logic             accept;
    logic             can_load;
    logic             load;
    logic             push;
    logic             pop;

    assign accept = in_valid && in_ready;
`ifdef SER_PARITY_EN
    assign can_load = state == IDLE || state == PARITY;
`else
    assign can_load = state == IDLE || (state == SHIFT && cnt == LAST);
`endif
    // The held word always goes first; a word accepted alongside it waits in hold.
    assign pop       = can_load && hold_full;
    assign push      = accept && !(can_load && !hold_full);
    assign load      = pop || (can_load && accept);
    assign next_word = hold_full ? hold_data : in_data;
    assign busy      = state != IDLE || hold_full;

    ser_word_buffer #(.WIDTH(WIDTH)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .din      (in_data),
        .dout     (hold_data),
        .full     (hold_full),
        .in_ready (in_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shifter    <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            ser_bit    <= IDLE_BIT;
            ser_valid  <= 1'b0;
            word_start <= 1'b0;
        end else begin
            ser_bit    <= state == SHIFT  ? (MSB_FIRST ? shifter[WIDTH-1] : shifter[0]) :
                          state == PARITY ? par : IDLE_BIT;
            ser_valid  <= state != IDLE;
            word_start <= state == SHIFT && cnt == '0;
            if (load) begin
                shifter <= next_word;
                par     <= ^next_word;
                cnt     <= '0;
                state   <= SHIFT;
            end else if (state == SHIFT) begin
                shifter <= MSB_FIRST ? shifter << 1 : shifter >> 1;
                if (cnt == LAST) begin
`ifdef SER_PARITY_EN
                    state <= PARITY;
`else
                    state <= IDLE;
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed self-checking bench for seq_bit_serializer (default parameters).
// Define SER_PARITY_EN for both bench and design to check the parity build.
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int P = 8;
`else
    localparam int P = 7;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ser_bit;
    logic       ser_valid;
    logic       word_start;
    logic       busy;

    int tests = 0;
    int fails = 0;

    seq_bit_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .word_start (word_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected bit at position pos of a word period: LSB-first data, then even parity.
    function automatic logic exp_bit(input logic [6:0] w, input int pos);
        return pos < 7 ? w[pos] : ^w;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 7'h53;
        for (int i = 0; i < 3; i++) step();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests++; if (ser_valid !== 1'b0) begin fails++; $display("FAIL reset_ser_valid got %b want 0", ser_valid); end
        tests++; if (ser_bit !== 1'b0) begin fails++; $display("FAIL reset_ser_bit got %b want 0", ser_bit); end
        tests++; if (word_start !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_ws_busy got %b%b want 00", word_start, busy); end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        logic [6:0] w;
        w = 7'h53;
        in_data = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if (ser_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_accept valid/busy got %b%b want 01", ser_valid, busy); end
        for (int i = 0; i < P; i++) begin
            step();
            tests++;
            if (ser_valid !== 1'b1 || ser_bit !== exp_bit(w, i) || word_start !== (i == 0)) begin
                fails++;
                $display("FAIL single_bit%0d got v=%b b=%b ws=%b want v=1 b=%b ws=%b", i, ser_valid, ser_bit, word_start, exp_bit(w, i), i == 0);
            end
        end
        step();
        tests++; if (ser_valid !== 1'b0 || ser_bit !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_idle got v=%b b=%b busy=%b want 000", ser_valid, ser_bit, busy); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] w [3];
        int k;
        logic acc;
        logic saw_stall;
        w[0] = 7'h53; w[1] = 7'h2A; w[2] = 7'h7F;
        k = 0;
        saw_stall = 1'b0;
        in_data = w[0];
        in_valid = 1'b1;
        for (int i = 0; i <= 3 * P + 1; i++) begin
            acc = in_valid && in_ready;
            if (in_valid && !in_ready) saw_stall = 1'b1;
            step();
            if (acc) begin
                k++;
                if (k < 3) in_data = w[k]; else in_valid = 1'b0;
            end
            if (i == 0 || i == 3 * P + 1) begin
                tests++; if (ser_valid !== 1'b0) begin fails++; $display("FAIL b2b_edge%0d ser_valid got %b want 0", i, ser_valid); end
            end else begin
                tests++;
                if (ser_valid !== 1'b1 || ser_bit !== exp_bit(w[(i-1)/P], (i-1)%P) || word_start !== ((i-1)%P == 0)) begin
                    fails++;
                    $display("FAIL b2b_bit%0d got v=%b b=%b ws=%b want v=1 b=%b ws=%b", i - 1, ser_valid, ser_bit, word_start, exp_bit(w[(i-1)/P], (i-1)%P), (i-1)%P == 0);
                end
            end
        end
        tests++; if (saw_stall !== 1'b1) begin fails++; $display("FAIL b2b_stall saw_in_ready_low got %b want 1", saw_stall); end
        tests++; if (k !== 3 || busy !== 1'b0) begin fails++; $display("FAIL b2b_done accepted=%0d busy=%b want 3 0", k, busy); end
    endtask

    task automatic test_reset_mid_word();
        in_data = 7'h7F;
        in_valid = 1'b1;
        step();
        in_data = 7'h7F;
        step();
        in_valid = 1'b0;
        step();
        step();
        tests++; if (in_ready !== 1'b0 || ser_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre hold/valid got rdy=%b v=%b want 0 1", in_ready, ser_valid); end
        rst = 1'b1;
        step();
        tests++; if (ser_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_clear got v=%b busy=%b want 0 0", ser_valid, busy); end
        rst = 1'b0;
        for (int i = 0; i < 2 * P + 2; i++) begin
            step();
            tests++; if (ser_valid !== 1'b0 || ser_bit !== 1'b0) begin fails++; $display("FAIL midrst_after%0d got v=%b b=%b want 0 0", i, ser_valid, ser_bit); end
        end
    endtask

    task automatic test_last_bit_accept();
        logic [6:0] a;
        logic [6:0] b;
        a = 7'h53;
        b = 7'h2A;
        in_data = a;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < P - 1; i++) step();
        in_data = b;
        in_valid = 1'b1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lastbit_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        tests++; if (ser_valid !== 1'b1 || ser_bit !== exp_bit(a, P - 1)) begin fails++; $display("FAIL lastbit_tail got v=%b b=%b want 1 %b", ser_valid, ser_bit, exp_bit(a, P - 1)); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lastbit_hold_empty in_ready got %b want 1", in_ready); end
        for (int i = 0; i < P; i++) begin
            step();
            tests++;
            if (ser_valid !== 1'b1 || ser_bit !== exp_bit(b, i) || word_start !== (i == 0)) begin
                fails++;
                $display("FAIL lastbit_next%0d got v=%b b=%b ws=%b want v=1 b=%b ws=%b", i, ser_valid, ser_bit, word_start, exp_bit(b, i), i == 0);
            end
        end
        step();
        tests++; if (ser_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL lastbit_idle got v=%b busy=%b want 0 0", ser_valid, busy); end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        in_data = 7'h2A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        tests++; if (ser_valid !== 1'b1 || ser_bit !== 1'b1 || word_start !== 1'b0) begin fails++; $display("FAIL parity_bit got v=%b b=%b ws=%b want 1 1 0", ser_valid, ser_bit, word_start); end
        step();
        tests++; if (ser_valid !== 1'b0) begin fails++; $display("FAIL parity_period got v=%b want 0", ser_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_word();
        test_last_bit_accept();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
